// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator programmed through byte-wide register writes.
// Duty and period writes land in shadow registers and are committed at period wrap.
module pwm_bank #(
  parameter int NUM_CH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  logic [NUM_CH-1:0] out_en_q, out_en_d;
  logic [NUM_CH-1:0] pwm_en_q, pwm_en_d;
  logic [NUM_CH-1:0] pol_q, pol_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [7:0]        prescale_q, prescale_d;
  logic [7:0]        top_sh_q, top_sh_d;
  logic [7:0]        top_act_q, top_act_d;
  logic [7:0]        pre_cnt_q, pre_cnt_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        duty_sh_q [NUM_CH];
  logic [7:0]        duty_sh_d [NUM_CH];
  logic [7:0]        duty_act_q [NUM_CH];
  logic [7:0]        duty_act_d [NUM_CH];
  logic              wrap_q, wrap_d;
  logic              period_start_q, period_start_d;
  logic              tick;
  logic              wrap;
  logic              raw_bit;

  always_comb begin
    tick      = (pre_cnt_q >= prescale_q);
    wrap      = tick && (cnt_q == top_act_q);
    pre_cnt_d = tick ? 8'd0 : pre_cnt_q + 8'd1;

    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = 8'd0;
    end else if (tick) begin
      cnt_d = cnt_q + 8'd1;
    end

    // Commit uses the shadow value from before any write landing in this same cycle.
    wrap_d         = wrap;
    period_start_d = wrap_q;
    top_act_d      = wrap ? top_sh_q : top_act_q;
    duty_act_d     = duty_act_q;
    if (wrap) begin
      duty_act_d = duty_sh_q;
    end

    prescale_d = prescale_q;
    top_sh_d   = top_sh_q;
    out_en_d   = out_en_q;
    pwm_en_d   = pwm_en_q;
    pol_d      = pol_q;
    duty_sh_d  = duty_sh_q;
    if (wr_en && wr_addr == 7'h0C) begin
      prescale_d = wr_data;
    end
    if (wr_en && wr_addr == 7'h0D) begin
      top_sh_d = wr_data;
    end

    raw_bit = 1'b0;
    out_d   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en && wr_addr == 7'(c / 8)) begin
        out_en_d[c] = wr_data[3'(c % 8)];
      end
      if (wr_en && wr_addr == 7'(4 + c / 8)) begin
        pwm_en_d[c] = wr_data[3'(c % 8)];
      end
      if (wr_en && wr_addr == 7'(8 + c / 8)) begin
        pol_d[c] = wr_data[3'(c % 8)];
      end
      if (wr_en && wr_addr == 7'(64 + c)) begin
        duty_sh_d[c] = wr_data;
      end

      raw_bit = (duty_act_q[c] == 8'hFF) || (cnt_q < duty_act_q[c]);
      if (!out_en_q[c]) begin
        out_d[c] = 1'b0;
      end else if (!pwm_en_q[c]) begin
        out_d[c] = ~pol_q[c];
      end else begin
        out_d[c] = raw_bit ^ pol_q[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_en_q       <= '0;
      pwm_en_q       <= '0;
      pol_q          <= '0;
      out_q          <= '0;
      prescale_q     <= 8'd0;
      top_sh_q       <= 8'hFF;
      top_act_q      <= 8'hFF;
      pre_cnt_q      <= 8'd0;
      cnt_q          <= 8'd0;
      wrap_q         <= 1'b0;
      period_start_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_sh_q[c]  <= 8'd0;
        duty_act_q[c] <= 8'd0;
      end
    end else begin
      out_en_q       <= out_en_d;
      pwm_en_q       <= pwm_en_d;
      pol_q          <= pol_d;
      out_q          <= out_d;
      prescale_q     <= prescale_d;
      top_sh_q       <= top_sh_d;
      top_act_q      <= top_act_d;
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      wrap_q         <= wrap_d;
      period_start_q <= period_start_d;
      duty_sh_q      <= duty_sh_d;
      duty_act_q     <= duty_act_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule
